// File: rtl/polar_pkg.sv
// rtl/polar_pkg.sv - shared polar decoder phase codes, frame geometry and phase enum
package polar_pkg;

    localparam int POLAR_CODE_LENGTH         = 1024;
    localparam int POLAR_INNER_COUNTER_WIDTH = 11;
    localparam int POLAR_STATE_WIDTH         = 10;

    // One-hot phase codes shared by the loader, the SC core and the output controller
    localparam logic [POLAR_STATE_WIDTH-1:0] POLAR_IDLE_STATE        = 10'd1;
    localparam logic [POLAR_STATE_WIDTH-1:0] POLAR_INPUT_STATE       = 10'd2;
    localparam logic [POLAR_STATE_WIDTH-1:0] POLAR_DECODE_STATE      = 10'd4;
    localparam logic [POLAR_STATE_WIDTH-1:0] POLAR_OUTPUT_WAIT_STATE = 10'd256;
    localparam logic [POLAR_STATE_WIDTH-1:0] POLAR_OUTPUT_STATE      = 10'd512;

    // Compact mirror of the one-hot bus; PHASE_ILLEGAL covers every non-legal bus value
    typedef enum logic [2:0] {
        PHASE_IDLE,
        PHASE_INPUT,
        PHASE_DECODE,
        PHASE_OUTPUT_WAIT,
        PHASE_OUTPUT,
        PHASE_ILLEGAL
    } frame_phase_t;

endpackage

// File: rtl/handshake_beat_counter.sv
// rtl/handshake_beat_counter.sv - stream beat counter with clear, enable and terminal flag
module handshake_beat_counter
    import polar_pkg::*;
#(
    parameter int WIDTH    = POLAR_INNER_COUNTER_WIDTH,
    parameter int TERMINAL = POLAR_CODE_LENGTH - 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             terminal
);

    // Clear wins over enable so a closing beat leaves the counter at zero
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + WIDTH'(1);
        end
    end

    assign terminal = (count == WIDTH'(TERMINAL));

endmodule

// File: rtl/polar_frame_sequencer.sv
// rtl/polar_frame_sequencer.sv - one-hot frame phase scheduler for the polar decoder
module polar_frame_sequencer
    import polar_pkg::*;
#(
    parameter int                              CODE_LENGTH         = POLAR_CODE_LENGTH,
    parameter int                              STATE_WIDTH         = POLAR_STATE_WIDTH,
    parameter logic [STATE_WIDTH-1:0]          IDLE_STATE          = POLAR_IDLE_STATE,
    parameter logic [STATE_WIDTH-1:0]          INPUT_STATE         = POLAR_INPUT_STATE,
    parameter logic [STATE_WIDTH-1:0]          DECODE_STATE        = POLAR_DECODE_STATE,
    parameter logic [STATE_WIDTH-1:0]          OUTPUT_WAIT_STATE   = POLAR_OUTPUT_WAIT_STATE,
    parameter logic [STATE_WIDTH-1:0]          OUTPUT_STATE        = POLAR_OUTPUT_STATE,
    parameter int                              INNER_COUNTER_WIDTH = POLAR_INNER_COUNTER_WIDTH,
    parameter int                              OUTPUT_WAIT_CYCLES  = 4,
    parameter int                              FRAME_COUNT_WIDTH   = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         saxis_tvalid,
    input  logic                         saxis_tlast,
    output logic                         saxis_tready,
    output logic                         decode_start,
    input  logic                         decode_done,
    input  logic                         maxis_tvalid,
    input  logic                         maxis_tready,
    input  logic                         maxis_tlast,
    output logic [STATE_WIDTH-1:0]       state,
    output logic                         frame_error,
    output logic [FRAME_COUNT_WIDTH-1:0] frames_done
);

    localparam int WAIT_WIDTH = 4;
    localparam logic [INNER_COUNTER_WIDTH-1:0] LAST_BEAT = INNER_COUNTER_WIDTH'(CODE_LENGTH - 1);

    logic [STATE_WIDTH-1:0]         state_r;
    logic [STATE_WIDTH-1:0]         state_next;
    frame_phase_t                   phase;
    logic [INNER_COUNTER_WIDTH-1:0] in_count;
    logic                           in_terminal;
    logic [INNER_COUNTER_WIDTH-1:0] out_beats_unused;
    logic                           out_terminal;
    logic                           in_hs;
    logic                           in_last_hs;
    logic                           out_hs;
    logic                           out_frame_end;
    logic [WAIT_WIDTH-1:0]          wait_count;
    logic                           wait_done;

    assign state        = state_r;
    assign saxis_tready = (state_r == INPUT_STATE);

    assign in_hs         = saxis_tvalid & saxis_tready;
    assign in_last_hs    = in_hs & in_terminal;
    assign out_hs        = (phase == PHASE_OUTPUT) & maxis_tvalid & maxis_tready;
    assign out_frame_end = out_hs & (maxis_tlast | out_terminal);
    assign wait_done     = (wait_count == WAIT_WIDTH'(OUTPUT_WAIT_CYCLES - 1));

    // Map the one-hot bus onto the phase enum; anything not exactly one legal code is illegal
    always_comb begin
        phase = PHASE_ILLEGAL;
        if (state_r == IDLE_STATE) begin
            phase = PHASE_IDLE;
        end else if (state_r == INPUT_STATE) begin
            phase = PHASE_INPUT;
        end else if (state_r == DECODE_STATE) begin
            phase = PHASE_DECODE;
        end else if (state_r == OUTPUT_WAIT_STATE) begin
            phase = PHASE_OUTPUT_WAIT;
        end else if (state_r == OUTPUT_STATE) begin
            phase = PHASE_OUTPUT;
        end
    end

    // Input beats: counts accepted LLR beats, cleared outside INPUT and on the closing beat
    handshake_beat_counter #(
        .WIDTH    (INNER_COUNTER_WIDTH),
        .TERMINAL (CODE_LENGTH - 1)
    ) u_in_counter (
        .clk      (clk),
        .reset    (reset),
        .clear    ((phase != PHASE_INPUT) | in_last_hs),
        .enable   (in_hs),
        .count    (in_count),
        .terminal (in_terminal)
    );

    // Output beats: counts downstream handshakes so a missing tlast still closes the frame
    handshake_beat_counter #(
        .WIDTH    (INNER_COUNTER_WIDTH),
        .TERMINAL (CODE_LENGTH - 1)
    ) u_out_counter (
        .clk      (clk),
        .reset    (reset),
        .clear    ((phase != PHASE_OUTPUT) | out_frame_end),
        .enable   (out_hs),
        .count    (out_beats_unused),
        .terminal (out_terminal)
    );

    // Phase register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE_STATE;
        end else begin
            state_r <= state_next;
        end
    end

    // Phase transitions; start at the end of OUTPUT chains straight into the next capture
    always_comb begin
        state_next = state_r;
        unique case (phase)
            PHASE_IDLE: begin
                if (start) begin
                    state_next = INPUT_STATE;
                end
            end
            PHASE_INPUT: begin
                if (in_last_hs) begin
                    state_next = DECODE_STATE;
                end
            end
            PHASE_DECODE: begin
                if (decode_done) begin
                    state_next = OUTPUT_WAIT_STATE;
                end
            end
            PHASE_OUTPUT_WAIT: begin
                if (wait_done) begin
                    state_next = OUTPUT_STATE;
                end
            end
            PHASE_OUTPUT: begin
                if (out_frame_end) begin
                    state_next = start ? INPUT_STATE : IDLE_STATE;
                end
            end
            default: begin
                state_next = IDLE_STATE;
            end
        endcase
    end

    // Settle counter for OUTPUT_WAIT; zero on entry and again as the phase is left
    always_ff @(posedge clk) begin
        if (reset || (phase != PHASE_OUTPUT_WAIT) || wait_done) begin
            wait_count <= '0;
        end else begin
            wait_count <= wait_count + WAIT_WIDTH'(1);
        end
    end

    // Single decode kick, high in the first DECODE cycle only
    always_ff @(posedge clk) begin
        if (reset) begin
            decode_start <= 1'b0;
        end else begin
            decode_start <= (phase == PHASE_INPUT) & in_last_hs;
        end
    end

    // Sticky framing error: tlast must coincide exactly with the final input beat
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_error <= 1'b0;
        end else if (in_hs && (saxis_tlast != (in_count == LAST_BEAT))) begin
            frame_error <= 1'b1;
        end
    end

    // Completed-frame counter, wraps naturally at its width
    always_ff @(posedge clk) begin
        if (reset) begin
            frames_done <= '0;
        end else if (out_frame_end) begin
            frames_done <= frames_done + FRAME_COUNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_polar_frame_sequencer.sv
// tb/tb_polar_frame_sequencer.sv - directed self-checking bench for polar_frame_sequencer
module tb_polar_frame_sequencer;

    localparam int CL = 1024;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        saxis_tvalid = 1'b0;
    logic        saxis_tlast = 1'b0;
    logic        saxis_tready;
    logic        decode_start;
    logic        decode_done = 1'b0;
    logic        maxis_tvalid = 1'b0;
    logic        maxis_tready = 1'b0;
    logic        maxis_tlast = 1'b0;
    logic [9:0]  state;
    logic        frame_error;
    logic [15:0] frames_done;

    int checks = 0;
    int errors = 0;
    int ds_pulses = 0;
    int idle_cycles = 0;

    polar_frame_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .saxis_tvalid (saxis_tvalid),
        .saxis_tlast  (saxis_tlast),
        .saxis_tready (saxis_tready),
        .decode_start (decode_start),
        .decode_done  (decode_done),
        .maxis_tvalid (maxis_tvalid),
        .maxis_tready (maxis_tready),
        .maxis_tlast  (maxis_tlast),
        .state        (state),
        .frame_error  (frame_error),
        .frames_done  (frames_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (decode_start === 1'b1) ds_pulses++;
        if (state === 10'd1) idle_cycles++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Feeds one full frame; tlast lands on beat last_at (CL-1 for a clean frame)
    task automatic send_input(input int last_at, input int stall_every, output int hs);
        hs = 0;
        for (int i = 0; i < CL; i++) begin
            if (stall_every > 0 && (i % stall_every) == 3) begin
                saxis_tvalid = 1'b0;
                saxis_tlast  = 1'b0;
                tick();
            end
            saxis_tvalid = 1'b1;
            saxis_tlast  = (i == last_at);
            if (saxis_tready === 1'b1) hs++;
            tick();
            if (i == 500 && last_at == 500) chk("early_tlast_error", frame_error, 1);
            if (i == CL - 2) chk("input_before_last", state, 10'd2);
        end
        saxis_tvalid = 1'b0;
        saxis_tlast  = 1'b0;
    endtask

    // Counts cycles spent in OUTPUT_WAIT, bounded
    task automatic measure_wait(output int n);
        n = 0;
        while (state === 10'd256 && n < 20) begin
            n++;
            tick();
        end
    endtask

    // Drives downstream handshakes until tlast_at (0 = never) or CL handshakes
    task automatic run_output(input int tlast_at, input bit toggle, output int h);
        int  c;
        bit  done;
        logic hs_now;
        h = 0;
        c = 0;
        done = 0;
        maxis_tvalid = 1'b1;
        while (!done && c < 5000) begin
            maxis_tready = toggle ? ((c % 2) == 0) : 1'b1;
            hs_now       = maxis_tready;
            maxis_tlast  = hs_now && (h + 1 == tlast_at);
            if (hs_now) h++;
            tick();
            c++;
            if ((hs_now && maxis_tlast) || h == CL) done = 1;
            else if (h == CL - 1 && hs_now) chk("output_before_last", state, 10'd512);
        end
        chk("output_bounded", c < 5000, 1);
        maxis_tvalid = 1'b0;
        maxis_tready = 1'b0;
        maxis_tlast  = 1'b0;
    endtask

    initial begin
        int hs;
        int n;
        int idle_snap;
        int ds_snap;

        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("reset_state", state, 10'd1);
        chk("reset_tready", saxis_tready, 0);
        chk("reset_decode_start", decode_start, 0);
        chk("reset_frame_error", frame_error, 0);
        chk("reset_frames_done", frames_done, 0);

        // Frame 1: clean input, 37-cycle decode, toggling output ready, start low
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("idle_to_input", state, 10'd2);
        chk("tready_in_input", saxis_tready, 1);
        send_input(CL - 1, 0, hs);
        chk("f1_input_handshakes", hs, CL);
        chk("f1_enter_decode", state, 10'd4);
        chk("f1_decode_start_pulse", decode_start, 1);
        chk("f1_tready_low", saxis_tready, 0);
        chk("f1_frame_error", frame_error, 0);
        tick();
        chk("f1_decode_start_single", decode_start, 0);
        for (int k = 0; k < 35; k++) tick();
        chk("f1_still_decode", state, 10'd4);
        decode_done = 1'b1;
        tick();
        decode_done = 1'b0;
        chk("f1_enter_wait", state, 10'd256);
        measure_wait(n);
        chk("f1_wait_cycles", n, 4);
        chk("f1_enter_output", state, 10'd512);
        run_output(CL, 1, hs);
        chk("f1_output_handshakes", hs, CL);
        chk("f1_back_to_idle", state, 10'd1);
        chk("f1_frames_done", frames_done, 1);
        chk("f1_ds_pulses", ds_pulses, 1);

        // Frame A: early tlast, same-cycle decode_done, early output tlast, start held
        start = 1'b1;
        tick();
        chk("fa_input", state, 10'd2);
        idle_snap = idle_cycles;
        ds_snap   = ds_pulses;
        send_input(500, 0, hs);
        chk("fa_enter_decode", state, 10'd4);
        chk("fa_error_sticky", frame_error, 1);
        decode_done = 1'b1;
        tick();
        decode_done = 1'b0;
        chk("fa_same_cycle_done", state, 10'd256);
        measure_wait(n);
        chk("fa_wait_cycles", n, 4);
        run_output(10, 0, hs);
        chk("fa_early_tlast_hs", hs, 10);
        chk("fa_direct_to_input", state, 10'd2);
        chk("fa_frames_done", frames_done, 2);

        // Frame B: stalled input, output closed by the beat count alone
        send_input(CL - 1, 7, hs);
        chk("fb_input_handshakes", hs, CL);
        chk("fb_enter_decode", state, 10'd4);
        for (int k = 0; k < 5; k++) tick();
        decode_done = 1'b1;
        tick();
        decode_done = 1'b0;
        measure_wait(n);
        chk("fb_wait_cycles", n, 4);
        run_output(0, 0, hs);
        chk("fb_output_handshakes", hs, CL);
        chk("fb_direct_to_input", state, 10'd2);
        chk("fb_frames_done", frames_done, 3);
        chk("ab_no_idle_cycles", idle_cycles - idle_snap, 0);
        chk("ab_two_decode_starts", ds_pulses - ds_snap, 2);
        chk("ab_error_still_set", frame_error, 1);

        // Frame C: reset in DECODE, late decode_done must be ignored
        start = 1'b0;
        send_input(CL - 1, 0, hs);
        chk("fc_enter_decode", state, 10'd4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ds_snap = ds_pulses;
        chk("fc_reset_idle", state, 10'd1);
        chk("fc_reset_error", frame_error, 0);
        chk("fc_reset_frames", frames_done, 0);
        tick();
        decode_done = 1'b1;
        tick();
        decode_done = 1'b0;
        tick();
        tick();
        chk("fc_done_ignored", state, 10'd1);
        chk("fc_no_decode_start", ds_pulses - ds_snap, 0);
        chk("fc_frames_zero", frames_done, 0);
        chk("fc_tready_low", saxis_tready, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
